// File: rtl/tlb_port_sched_pkg.sv
// tlb_port_sched_pkg: op codes, FSM states and owner codes shared by the
// TLB port scheduler and its latency counter.
package tlb_port_sched_pkg;
    localparam logic [1:0] OP_TLBP  = 2'b01;
    localparam logic [1:0] OP_TLBR  = 2'b10;
    localparam logic [1:0] OP_TLBWI = 2'b11;
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOOK   = 2'b01,
        S_OPRUN  = 2'b10,
        S_OPHOLD = 2'b11
    } state_t;
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_I    = 2'b01,
        OWN_D    = 2'b10,
        OWN_OP   = 2'b11
    } owner_t;
endpackage

// File: rtl/tlb_sched_lat_cnt.sv
// tlb_sched_lat_cnt: TLB latency down-counter; o_fire marks the result cycle,
// o_zombie stays set after an abandoned transaction until its result drains.
module tlb_sched_lat_cnt #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_kill,
    output logic o_fire,
    output logic o_zombie
);
    logic [1:0] r_cnt;
    logic       r_fire;
    logic       r_zombie;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_fire   <= 1'b0;
            r_zombie <= 1'b0;
        end else begin
            r_cnt    <= i_load ? 2'(LAT) : (r_cnt != 2'd0 ? r_cnt - 2'd1 : 2'd0);
            r_fire   <= r_cnt == 2'd1;
            r_zombie <= (r_zombie | i_kill) & ~r_fire;
        end
    end
    assign o_fire   = r_fire;
    assign o_zombie = r_zombie;
endmodule

// File: rtl/tlb_port_sched.sv
// tlb_port_sched: arbitrates the single TLB port among I/D translation and CP0
// TLB ops. Define TLB_SCHED_PERF_EN to add per-requester wait-cycle counters.
module tlb_port_sched
    import tlb_port_sched_pkg::*;
#(
    parameter int TLB_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        i_req,
    input  logic [31:0] i_vaddr,
    output logic        i_gnt,
    output logic        i_rvalid,
    input  logic        d_req,
    input  logic [31:0] d_vaddr,
    output logic        d_gnt,
    output logic        d_rvalid,
    input  logic        op_req,
    input  logic [1:0]  op_type,
    output logic        op_gnt,
    output logic        op_done,
    output logic [31:0] tlb_vaddr,
    output logic        tlb_lookup_valid,
    output logic        tlb_op_tlbp,
    output logic        tlb_op_tlbr,
    output logic        tlb_op_tlbwi,
    output logic        stallreq_for_tlb,
    output logic        busy
`ifdef TLB_SCHED_PERF_EN
    ,
    output logic [31:0] perf_i_wait,
    output logic [31:0] perf_d_wait
`endif
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_t        r_state, w_nxt;
    owner_t        r_owner;
    logic [1:0]    r_op;
    logic          r_sup;
    logic [SW-1:0] r_starve;
    logic          r_lv, r_tlbp, r_tlbr, r_tlbwi;
    logic [31:0]   r_vaddr;
    logic w_fire, w_zombie, w_look, w_oprun, w_hold, w_legal_op, w_can, w_force;
    logic w_op_g, w_i_g, w_d_g, w_kill;

    assign w_look     = r_state == S_LOOK;
    assign w_oprun    = r_state == S_OPRUN;
    assign w_hold     = r_state == S_OPHOLD;
    assign w_legal_op = op_req & (op_type != 2'b00);
    // Reset also gates grants so nothing combinational escapes while rst is high.
    assign w_can   = ~rst & ~flush & ~w_zombie & (r_state == S_IDLE | w_hold | (w_look & w_fire));
    assign w_force = r_starve == SW'(STARVE_MAX);
    assign w_op_g  = w_can & w_legal_op;
    assign w_i_g   = w_can & ~w_legal_op & i_req & (w_force | ~d_req);
    assign w_d_g   = w_can & ~w_legal_op & d_req & ~(w_force & i_req);
    // tlbwi has already modified the TLB once issued, so it is never abandoned.
    assign w_kill  = flush & (w_look | (w_oprun & r_op != OP_TLBWI));

    tlb_sched_lat_cnt #(.LAT(TLB_LAT)) u_lat (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_op_g | w_i_g | w_d_g),
        .i_kill   (w_kill),
        .o_fire   (w_fire),
        .o_zombie (w_zombie)
    );

    always_comb begin
        w_nxt = w_op_g ? S_OPRUN :
                (w_i_g | w_d_g) ? S_LOOK :
                (w_kill | w_hold | (w_look & w_fire)) ? S_IDLE :
                (w_oprun & w_fire) ? S_OPHOLD : r_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= OWN_NONE;
            r_op     <= '0;
            r_sup    <= 1'b0;
            r_starve <= '0;
            r_lv     <= 1'b0;
            r_tlbp   <= 1'b0;
            r_tlbr   <= 1'b0;
            r_tlbwi  <= 1'b0;
            r_vaddr  <= '0;
        end else begin
            r_state  <= w_nxt;
            r_owner  <= w_op_g ? OWN_OP : w_i_g ? OWN_I : w_d_g ? OWN_D :
                        (w_nxt == S_IDLE) ? OWN_NONE : r_owner;
            r_op     <= w_op_g ? op_type : r_op;
            r_sup    <= ~w_op_g & (r_sup | (flush & w_oprun));
            r_starve <= (w_d_g & i_req) ? (w_force ? r_starve : r_starve + SW'(1)) :
                        (w_i_g | ~i_req) ? '0 : r_starve;
            r_lv     <= w_i_g | w_d_g;
            r_tlbp   <= w_op_g & (op_type == OP_TLBP);
            r_tlbr   <= w_op_g & (op_type == OP_TLBR);
            r_tlbwi  <= w_op_g & (op_type == OP_TLBWI);
            r_vaddr  <= w_i_g ? i_vaddr : w_d_g ? d_vaddr : r_vaddr;
        end
    end

    assign i_gnt            = w_i_g;
    assign d_gnt            = w_d_g;
    assign op_gnt           = w_op_g;
    assign i_rvalid         = w_look & w_fire & ~flush & (r_owner == OWN_I);
    assign d_rvalid         = w_look & w_fire & ~flush & (r_owner == OWN_D);
    assign op_done          = w_oprun & w_fire & ~w_kill;
    assign tlb_vaddr        = r_vaddr;
    assign tlb_lookup_valid = r_lv;
    assign tlb_op_tlbp      = r_tlbp;
    assign tlb_op_tlbr      = r_tlbr;
    assign tlb_op_tlbwi     = r_tlbwi;
    // Stall drops in OPHOLD so CP0 captures the result on the following cycle.
    assign stallreq_for_tlb = ~rst & ((w_legal_op & ~(w_oprun | w_hold)) | (w_oprun & ~flush & ~r_sup));
    assign busy             = r_state != S_IDLE;

`ifdef TLB_SCHED_PERF_EN
    logic [31:0] r_pi, r_pd;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pi <= '0;
            r_pd <= '0;
        end else begin
            r_pi <= r_pi + 32'(i_req & ~w_i_g);
            r_pd <= r_pd + 32'(d_req & ~w_d_g);
        end
    end
    assign perf_i_wait = r_pi;
    assign perf_d_wait = r_pd;
`endif
endmodule

// File: tb/tb_tlb_port_sched.sv
// tb_tlb_port_sched: directed checks of tlb_port_sched with TLB_LAT=1 (u_dut)
// and TLB_LAT=3 (u_dut3) driven from the same inputs.
module tb_tlb_port_sched;
    logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic i_req = 1'b0, d_req = 1'b0, op_req = 1'b0;
    logic [31:0] i_vaddr = '0, d_vaddr = '0;
    logic [1:0] op_type = '0;
    logic i_gnt, i_rvalid, d_gnt, d_rvalid, op_gnt, op_done, tlb_lookup_valid;
    logic tlb_op_tlbp, tlb_op_tlbr, tlb_op_tlbwi, stall, busy;
    logic i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, op_gnt3, op_done3, tlb_lookup_valid3;
    logic tlb_op_tlbp3, tlb_op_tlbr3, tlb_op_tlbwi3, stall3, busy3;
    logic [31:0] tlb_vaddr, tlb_vaddr3;
`ifdef TLB_SCHED_PERF_EN
    logic [31:0] pi1, pd1, pi3, pd3;
`endif
    logic [11:0] o1, o3;
    int n_chk = 0, n_fail = 0;

    assign o1 = {i_gnt, i_rvalid, d_gnt, d_rvalid, op_gnt, op_done, tlb_lookup_valid,
                 tlb_op_tlbp, tlb_op_tlbr, tlb_op_tlbwi, stall, busy};
    assign o3 = {i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, op_gnt3, op_done3, tlb_lookup_valid3,
                 tlb_op_tlbp3, tlb_op_tlbr3, tlb_op_tlbwi3, stall3, busy3};

    always #5 clk = ~clk;

    tlb_port_sched #(.TLB_LAT(1), .STARVE_MAX(4)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .op_req(op_req), .op_type(op_type), .op_gnt(op_gnt), .op_done(op_done),
        .tlb_vaddr(tlb_vaddr), .tlb_lookup_valid(tlb_lookup_valid),
        .tlb_op_tlbp(tlb_op_tlbp), .tlb_op_tlbr(tlb_op_tlbr), .tlb_op_tlbwi(tlb_op_tlbwi),
        .stallreq_for_tlb(stall), .busy(busy)
`ifdef TLB_SCHED_PERF_EN
        , .perf_i_wait(pi1), .perf_d_wait(pd1)
`endif
    );

    tlb_port_sched #(.TLB_LAT(3), .STARVE_MAX(4)) u_dut3 (
        .clk(clk), .rst(rst), .flush(flush),
        .i_req(i_req), .i_vaddr(i_vaddr), .i_gnt(i_gnt3), .i_rvalid(i_rvalid3),
        .d_req(d_req), .d_vaddr(d_vaddr), .d_gnt(d_gnt3), .d_rvalid(d_rvalid3),
        .op_req(op_req), .op_type(op_type), .op_gnt(op_gnt3), .op_done(op_done3),
        .tlb_vaddr(tlb_vaddr3), .tlb_lookup_valid(tlb_lookup_valid3),
        .tlb_op_tlbp(tlb_op_tlbp3), .tlb_op_tlbr(tlb_op_tlbr3), .tlb_op_tlbwi(tlb_op_tlbwi3),
        .stallreq_for_tlb(stall3), .busy(busy3)
`ifdef TLB_SCHED_PERF_EN
        , .perf_i_wait(pi3), .perf_d_wait(pd3)
`endif
    );

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic gap;
        i_req = 0; d_req = 0; op_req = 0; op_type = 2'b00; flush = 0;
        repeat (8) nxt();
        @(negedge clk);
        n_chk++;
        if ({busy, busy3} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_gap: busy got %b expected 00", {busy, busy3});
        end
        nxt();
    endtask

    task automatic test_reset;
        #1 rst = 1;
        i_req = 1; d_req = 1; op_req = 1; op_type = 2'b11;
        #1;
        n_chk++;
        if ({o1, o3, tlb_vaddr, tlb_vaddr3} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h expected 0", o1, o3);
        end
        @(negedge clk);
        n_chk++;
        if ({o1, o3} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h/%h expected 0", o1, o3);
        end
        @(posedge clk);
        #1;
        rst = 0; i_req = 0; d_req = 0; op_req = 0; op_type = 2'b00;
    endtask

    task automatic test_i_lookup;
        logic [3:0] e [4] = '{4'b1000, 4'b0101, 4'b0011, 4'b0000};
        for (int c = 0; c < 4; c++) begin
            i_req = (c == 0); i_vaddr = 32'h0040_0000;
            @(negedge clk);
            n_chk++;
            if ({i_gnt, tlb_lookup_valid, i_rvalid, busy} !== e[c]) begin
                n_fail++;
                $display("FAIL i_lookup cyc %0d: got %b expected %b", c,
                         {i_gnt, tlb_lookup_valid, i_rvalid, busy}, e[c]);
            end
            if (c == 1) begin
                n_chk++;
                if (tlb_vaddr !== 32'h0040_0000) begin
                    n_fail++;
                    $display("FAIL i_vaddr: got %h expected 00400000", tlb_vaddr);
                end
            end
            nxt();
        end
    endtask

    task automatic test_starve;
        int k = 0;
        i_req = 1; d_req = 1; i_vaddr = 32'h0000_1000; d_vaddr = 32'h8000_2000;
        for (int c = 0; c < 40 && k < 12; c++) begin
            @(negedge clk);
            if (i_gnt | d_gnt) begin
                n_chk++;
                if ({i_gnt, d_gnt} !== ((k == 4 || k == 9) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL starve grant %0d: got i/d %b expected %b", k,
                             {i_gnt, d_gnt}, (k == 4 || k == 9) ? 2'b10 : 2'b01);
                end
                k++;
            end
            nxt();
        end
        n_chk++;
        if (k != 12) begin
            n_fail++;
            $display("FAIL starve_count: got %0d grants expected 12", k);
        end
        i_req = 0; d_req = 0;
    endtask

    task automatic test_op_during_d;
        logic [6:0] e [7] = '{7'b1000000, 7'b0000011, 7'b0110011, 7'b0001011,
                             7'b0000111, 7'b0000001, 7'b0000000};
        for (int c = 0; c < 7; c++) begin
            d_req = (c == 0); d_vaddr = 32'h1000_0040;
            op_req = (c >= 1 && c <= 4); op_type = 2'b11;
            @(negedge clk);
            n_chk++;
            if ({d_gnt, d_rvalid, op_gnt, tlb_op_tlbwi, op_done, stall, busy} !== e[c]) begin
                n_fail++;
                $display("FAIL op_after_d cyc %0d: got %b expected %b", c,
                         {d_gnt, d_rvalid, op_gnt, tlb_op_tlbwi, op_done, stall, busy}, e[c]);
            end
            nxt();
        end
    endtask

    task automatic test_illegal_op;
        logic [3:0] e [3] = '{4'b0000, 4'b0000, 4'b1000};
        for (int c = 0; c < 3; c++) begin
            op_req = 1; op_type = 2'b00; d_req = (c == 2); d_vaddr = 32'h2000_0000;
            @(negedge clk);
            n_chk++;
            if ({d_gnt, op_gnt, stall, busy} !== e[c]) begin
                n_fail++;
                $display("FAIL illegal_op cyc %0d: got %b expected %b", c,
                         {d_gnt, op_gnt, stall, busy}, e[c]);
            end
            nxt();
        end
        op_req = 0; d_req = 0;
    endtask

    task automatic test_flush_lookup;
        logic [2:0] e [11] = '{3'b100, 3'b001, 3'b001, 3'b000, 3'b000, 3'b100,
                              3'b001, 3'b001, 3'b001, 3'b011, 3'b000};
        for (int c = 0; c < 11; c++) begin
            d_req = (c == 0) || (c >= 2 && c <= 5); d_vaddr = 32'h3000_0000 + 32'(c);
            flush = (c == 2);
            @(negedge clk);
            n_chk++;
            if ({d_gnt3, d_rvalid3, busy3} !== e[c]) begin
                n_fail++;
                $display("FAIL flush_lookup cyc %0d: got %b expected %b", c,
                         {d_gnt3, d_rvalid3, busy3}, e[c]);
            end
            nxt();
        end
        flush = 0; d_req = 0;
    endtask

    task automatic test_flush_op(input logic [1:0] t);
        logic [4:0] ew [7] = '{5'b10010, 5'b01011, 5'b00001, 5'b00001, 5'b00101, 5'b00001, 5'b00000};
        logic [4:0] ep [7] = '{5'b10010, 5'b01011, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
        logic [4:0] got, exp;
        for (int c = 0; c < 7; c++) begin
            op_req = (c < 2); op_type = t; flush = (c == 2);
            @(negedge clk);
            got = {op_gnt3, (t == 2'b11) ? tlb_op_tlbwi3 : tlb_op_tlbp3, op_done3, stall3, busy3};
            exp = (t == 2'b11) ? ew[c] : ep[c];
            n_chk++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL flush_op type %b cyc %0d: got %b expected %b", t, c, got, exp);
            end
            nxt();
        end
        flush = 0; op_req = 0;
    endtask

    task automatic test_async_reset;
        logic [2:0] e [5] = '{3'b001, 3'b001, 3'b001, 3'b101, 3'b000};
        op_req = 1; op_type = 2'b11;
        @(negedge clk);
        n_chk++;
        if (op_gnt3 !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_grant: got %b expected 1", op_gnt3);
        end
        nxt();
        @(negedge clk);
        n_chk++;
        if ({tlb_op_tlbwi3, busy3} !== 2'b11) begin
            n_fail++;
            $display("FAIL areset_issue: got %b expected 11", {tlb_op_tlbwi3, busy3});
        end
        nxt();
        #2 rst = 1; i_req = 1; i_vaddr = 32'h0055_0000;
        #1;
        n_chk++;
        if ({o1, o3, tlb_vaddr, tlb_vaddr3} !== '0) begin
            n_fail++;
            $display("FAIL areset_immediate: got %h/%h vaddr %h expected 0", o1, o3, tlb_vaddr3);
        end
        @(negedge clk);
        n_chk++;
        if ({i_gnt3, stall3, busy3} !== 3'b000) begin
            n_fail++;
            $display("FAIL areset_held: got %b expected 000", {i_gnt3, stall3, busy3});
        end
        nxt();
        rst = 0; op_req = 0;
        @(negedge clk);
        n_chk++;
        if ({i_gnt3, busy3} !== 2'b10) begin
            n_fail++;
            $display("FAIL areset_first_grant: got %b expected 10", {i_gnt3, busy3});
        end
        nxt();
        i_req = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_chk++;
            if ({i_rvalid3, op_done3, busy3} !== e[c]) begin
                n_fail++;
                $display("FAIL areset_after cyc %0d: got %b expected %b", c,
                         {i_rvalid3, op_done3, busy3}, e[c]);
            end
            nxt();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_i_lookup();
        gap();
        test_starve();
        gap();
        test_op_during_d();
        gap();
        test_illegal_op();
        gap();
        test_flush_lookup();
        gap();
        test_flush_op(2'b11);
        gap();
        test_flush_op(2'b01);
        gap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tlb_port_sched.md
Name: tlb_port_sched

Overview:
- Schedules the single TLB lookup/maintenance port among three requesters: instruction-fetch translation (I), data-access translation (D), and CP0 TLB instructions (tlbp/tlbr/tlbwi).
- Sits between IF/MEM/CP0 and the TLB.
- Keeps at most one transaction in flight, routes each result back to its owner, and raises a pipeline stall while a CP0 TLB op is in progress.

Parameters:
- TLB_LAT, 1: cycles from the issue cycle to the TLB result-valid cycle (1..3).
- STARVE_MAX, 4: consecutive D grants allowed while I is pending before I is forced.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  pipeline flush (exception/eret)
- i_req  in  1  I translation request
- i_vaddr  in  32  I virtual address
- i_gnt  out  1  I accepted (combinational)
- i_rvalid  out  1  I result pulse
- d_req  in  1  D translation request
- d_vaddr  in  32  D virtual address
- d_gnt  out  1  D accepted
- d_rvalid  out  1  D result pulse
- op_req  in  1  CP0 TLB op request (level, held until op_done)
- op_type  in  2  01 tlbp, 10 tlbr, 11 tlbwi; 00 illegal, ignored
- op_gnt  out  1  op accepted
- op_done  out  1  op result pulse
- tlb_vaddr  out  32  registered lookup address
- tlb_lookup_valid  out  1  registered lookup strobe
- tlb_op_tlbp  out  1  registered one-hot op strobe
- tlb_op_tlbr  out  1  registered one-hot op strobe
- tlb_op_tlbwi  out  1  registered one-hot op strobe
- stallreq_for_tlb  out  1  pipeline stall request
- busy  out  1  transaction in flight

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0, FSM IDLE, owner NONE, latency and starve counters 0, tlb_vaddr 0.
- FSM states:
  - IDLE: no transaction.
  - LOOK: I/D lookup in flight.
  - OPRUN: CP0 op in flight.
  - OPHOLD: one cycle after the op result, for CP0 capture.
- Grant rules: grants occur only in IDLE, or in LOOK/OPHOLD on the cycle the current transaction completes (back-to-back). At most one grant per cycle. Priority:
  - op_req (legal op_type) first.
  - Then I, if starve count equals STARVE_MAX.
  - Then D.
  - Then I.
- Grant cycle T:
  - gnt=1 combinationally.
  - At T+1: tlb_lookup_valid or the op strobe is 1 for exactly one cycle, and tlb_vaddr is registered.
  - Owner and FSM are updated at T+1.
- Latency counter loads TLB_LAT at issue. Result cycle = T+1+TLB_LAT; the owner's rvalid/op_done pulses 1 cycle there.
- LOOK -> IDLE on the result cycle, unless re-granted.
- OPRUN -> OPHOLD on the result cycle. OPHOLD -> IDLE after 1 cycle.
- Starve counter:
  - Increments on a D grant while i_req=1.
  - Clears on an I grant, or when i_req=0.
  - Saturates at STARVE_MAX.
- stallreq_for_tlb = (op_req & legal & FSM not in OPRUN/OPHOLD) | OPRUN. It drops in OPHOLD so CP0 captures the result the following cycle.
- busy = FSM != IDLE.
- flush:
  - In LOOK: the transaction is abandoned; no rvalid; FSM -> IDLE next cycle. A TLB result arriving later is ignored by the counter drain: an internal "zombie" bit blocks new grants until the latency counter expires.
  - In OPRUN with tlbp/tlbr: same treatment, no op_done.
  - tlbwi already issued is never aborted: op_done still pulses and OPHOLD still occurs; stall is suppressed from the flush cycle on.
  - Requests presented on the flush cycle are not granted.
- Simultaneous i_req and d_req with starve<STARVE_MAX: D wins. With starve=STARVE_MAX: I wins.
- op_type 00 with op_req=1: no grant, no stall.
- Reset asserted mid-transaction clears everything immediately; a subsequent TLB result is ignored.

Optional Feature:
- Macro TLB_SCHED_PERF_EN.
- With it defined: adds outputs perf_i_wait[31:0] and perf_d_wait[31:0]. Each counts cycles where req=1 and gnt=0, wraps at 2^32, is cleared by rst, and is unaffected by flush.
- Without it: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines header holds:
  - op_type codes (01/10/11).
  - FSM encodings IDLE=2'b00, LOOK=2'b01, OPRUN=2'b10, OPHOLD=2'b11.
  - Owner codes NONE/I/D/OP.
- One natural sub-module: tlb_sched_lat_cnt, the latency down-counter with zombie-drain flag, reused for the I/D/op paths.

Test Plan:
- TLB_LAT=1; i_req=1, vaddr 0x0040_0000 at cycle 0. Expected: i_gnt@0, tlb_lookup_valid+vaddr@1, i_rvalid@2, busy 1..2.
- i_req and d_req held high for 12 grants, STARVE_MAX=4. Expected grant sequence D,D,D,D,I,D,D,D,D,I,D,D.
- op_req tlbwi while D is in LOOK. Expected: op granted on D's result cycle; tlb_op_tlbwi one cycle later; op_done 1 cycle after that; stall high from op_req until the OPHOLD cycle, low in OPHOLD.
- flush during a D lookup with TLB_LAT=3. Expected: no d_rvalid; no grants until the counter drains; grant on the following cycle.
- flush one cycle after a tlbwi issue. Expected: op_done still pulses; stall low from the flush cycle. Same stimulus with tlbp: no op_done.
- rst asserted asynchronously mid-OPRUN. Expected: all outputs 0 immediately; first grant only after rst is deasserted.
